// File: rtl/viterbi_pkg.sv
// Shared types for the Viterbi survivor-memory scheduler.
// Holds the controller state enum, default block size and pair type.
package viterbi_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    WAIT_TB = 1'b1
  } state_t;

  localparam int BLK_LEN_DEF = 256;

  typedef logic [1:0] pair_t;

endpackage

// File: rtl/viterbi_sched_if.sv
// Symbol stream, survivor-write and traceback signals of the
// scheduler, bundled with a modport for each side.
interface viterbi_sched_if
  import viterbi_pkg::*;
#(
  parameter int AW = 8
);

  logic          in_valid;
  pair_t         rx_pair_in;
  logic          in_ready;
  logic          flush;
  pair_t         rx_pair;
  logic          acs_en;
  logic [AW-1:0] wr_addr;
  logic          wr_bank;
  logic          tb_req;
  logic          tb_bank;
  logic [AW:0]   tb_len;
  logic          tb_busy;
  logic [31:0]   sym_cnt;

  modport slave (
    input  in_valid, rx_pair_in, flush, tb_busy,
    output in_ready, rx_pair, acs_en, wr_addr,
    output wr_bank, tb_req, tb_bank, tb_len,
    output sym_cnt
  );

  modport master (
    output in_valid, rx_pair_in, flush, tb_busy,
    input  in_ready, rx_pair, acs_en, wr_addr,
    input  wr_bank, tb_req, tb_bank, tb_len,
    input  sym_cnt
  );

endinterface

// File: rtl/viterbi_sched.sv
// Survivor-memory block scheduler: fills two ping-pong banks and
// hands each closed bank to the traceback engine.
module viterbi_sched
  import viterbi_pkg::*;
#(
  parameter int BLK_LEN = BLK_LEN_DEF,
  parameter int AW      = $clog2(BLK_LEN)
) (
  input logic             clk,
  input logic             rst,
  viterbi_sched_if.slave  bus
);

  localparam logic [AW-1:0] LAST = AW'(BLK_LEN - 1);

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] fill;
  logic          bank;
  logic          accept;
  logic          busy_eff;
  logic          close;
  logic          issue;
  logic [AW:0]   len;

  assign bus.in_ready = (state == RUN);

  always_comb begin
    accept   = bus.in_valid && (state == RUN);
    // tb_busy lags tb_req by a cycle; the pulse itself counts as busy
    busy_eff = bus.tb_busy || bus.tb_req;
    len      = {1'b0, fill} + {{AW{1'b0}}, accept};
    close    = (state == RUN) &&
               ((accept && fill == LAST) ||
                (bus.flush && len != '0));
    issue    = 1'b0;
    state_n  = state;
    unique case (1'b1)
      (state == RUN): begin
        if (close) begin
          if (busy_eff) state_n = WAIT_TB;
          else          issue   = 1'b1;
        end
      end
      (state == WAIT_TB): begin
        if (!busy_eff) begin
          issue   = 1'b1;
          state_n = RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill        <= '0;
      bus.rx_pair <= '0;
      bus.acs_en  <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_bank <= 1'b0;
      bus.sym_cnt <= '0;
    end else begin
      bus.acs_en <= accept;
      if (accept) begin
        bus.rx_pair <= bus.rx_pair_in;
        bus.wr_addr <= fill;
        bus.wr_bank <= bank;
        bus.sym_cnt <= bus.sym_cnt + 32'd1;
      end
      if (close)       fill <= '0;
      else if (accept) fill <= fill + 1'b1;
    end
  end

  // tb_bank/tb_len double as the pending-request store in WAIT_TB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank        <= 1'b0;
      bus.tb_req  <= 1'b0;
      bus.tb_bank <= 1'b0;
      bus.tb_len  <= '0;
    end else begin
      bus.tb_req <= issue;
      if (close) begin
        bus.tb_bank <= bank;
        bus.tb_len  <= len;
      end
      if (issue) bank <= ~bank;
    end
  end

endmodule

// File: tb/tb_viterbi_sched.sv
// Self-checking bench for viterbi_sched: directed block scenarios
// plus a long randomized run against a block-level reference model.
module tb_viterbi_sched;
  import viterbi_pkg::*;

  localparam int BLK = 256;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_sched_if #(.AW(AW)) bus();

  viterbi_sched #(.BLK_LEN(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  bit          m_wait;
  int          m_fill;
  bit          m_bank;
  int unsigned m_sym;
  bit          e_acs;
  int          e_addr;
  bit          e_wbank;
  bit [1:0]    e_pair;
  bit          e_req;
  bit          e_tbbank;
  int          e_len;
  int unsigned n_acc;
  bit          act_ok;
  bit          act_bank;
  bit          prev_req;
  int          req_cnt;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_wait = 0; m_fill = 0; m_bank = 0; m_sym = 0;
    e_acs = 0; e_addr = 0; e_wbank = 0; e_pair = 0;
    e_req = 0; e_tbbank = 0; e_len = 0;
    n_acc = 0; act_ok = 0; act_bank = 0; prev_req = 0;
    req_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.rx_pair_in = 0;
    bus.flush = 0; bus.tb_busy = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  // One clock: drive at negedge, predict, check after the edge.
  task automatic step(bit v, bit [1:0] p, bit f, bit b);
    bit busy;
    bit acc;
    int n;
    bus.in_valid = v; bus.rx_pair_in = p;
    bus.flush = f; bus.tb_busy = b;
    #1;
    check("in_ready", bus.in_ready, !m_wait);
    if (v && bus.in_ready) n_acc++;
    if (bus.acs_en && (b || prev_req) && act_ok)
      check("bank_clash", bus.wr_bank != act_bank, 1);
    if (bus.tb_req) begin
      act_bank = bus.tb_bank;
      act_ok = 1;
    end
    prev_req = bus.tb_req;

    busy  = b || e_req;
    acc   = v && !m_wait;
    n     = m_fill + int'(acc);
    e_acs = acc;
    if (acc) begin
      e_pair = p; e_addr = m_fill; e_wbank = m_bank;
      m_sym++;
    end
    e_req = 0;
    if (!m_wait) begin
      if (n == BLK || (f && n > 0)) begin
        e_tbbank = m_bank; e_len = n; m_fill = 0;
        if (busy) m_wait = 1;
        else begin e_req = 1; m_bank = ~m_bank; end
      end else m_fill = n;
    end else if (!busy) begin
      e_req = 1; m_bank = ~m_bank; m_wait = 0;
    end

    @(posedge clk);
    @(negedge clk);
    check("acs_en", bus.acs_en, e_acs);
    if (e_acs) begin
      check("wr_addr", bus.wr_addr, e_addr);
      check("wr_bank", bus.wr_bank, e_wbank);
      check("rx_pair", bus.rx_pair, e_pair);
    end
    check("tb_req", bus.tb_req, e_req);
    if (e_req) begin
      check("tb_bank", bus.tb_bank, e_tbbank);
      check("tb_len", bus.tb_len, e_len);
    end
    if (bus.tb_req) begin
      check("req_b2b", prev_req, 0);
      req_cnt++;
    end
    check("sym_cnt", bus.sym_cnt, m_sym);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_acs"}, bus.acs_en, 0);
    check({tag, "_addr"}, bus.wr_addr, 0);
    check({tag, "_wbank"}, bus.wr_bank, 0);
    check({tag, "_pair"}, bus.rx_pair, 0);
    check({tag, "_req"}, bus.tb_req, 0);
    check({tag, "_tbbank"}, bus.tb_bank, 0);
    check({tag, "_len"}, bus.tb_len, 0);
    check({tag, "_sym"}, bus.sym_cnt, 0);
    check({tag, "_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    bit v, f, b;
    m_reset();
    do_reset();
    check_zero("rst0");

    // full block, engine idle
    for (int i = 0; i < BLK; i++)
      step(1, 2'($urandom), 0, 0);
    check("s1_req", bus.tb_req, 1);
    check("s1_bank", bus.tb_bank, 0);
    check("s1_len", bus.tb_len, 256);
    check("s1_last", bus.wr_addr, 255);
    step(1, 2'b10, 0, 0);
    check("s1_nbank", bus.wr_bank, 1);

    // partial block closed by flush
    do_reset();
    for (int i = 0; i < 100; i++)
      step(1, 2'($urandom), 0, 0);
    step(0, 0, 1, 0);
    check("s2_req", bus.tb_req, 1);
    check("s2_len", bus.tb_len, 100);
    check("s2_bank", bus.tb_bank, 0);
    step(1, 2'b01, 0, 0);
    check("s2_addr", bus.wr_addr, 0);
    check("s2_wbank", bus.wr_bank, 1);

    // second block closes while engine busy
    for (int i = 1; i < BLK; i++)
      step(1, 2'($urandom), 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'($urandom), 0, 1);
      check("s3_wait", bus.in_ready, 0);
    end
    step(1, 0, 0, 0);
    check("s3_req", bus.tb_req, 1);
    check("s3_bank", bus.tb_bank, 1);
    check("s3_len", bus.tb_len, 256);
    check("s3_ready", bus.in_ready, 1);

    // flush on the final accept of a full block
    do_reset();
    for (int i = 0; i < BLK - 1; i++)
      step(1, 2'($urandom), 0, 0);
    req_cnt = 0;
    step(1, 2'b11, 1, 0);
    check("s4_len", bus.tb_len, 256);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("s4_once", req_cnt, 1);

    // async reset mid-block
    do_reset();
    for (int i = 0; i < 50; i++)
      step(1, 2'($urandom), 0, 0);
    #2 rst = 1'b1;
    #1 check_zero("arst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst_noreq", bus.tb_req, 0);
    end
    rst = 1'b0;
    m_reset();
    step(1, 2'b01, 0, 0);
    check("arst_addr", bus.wr_addr, 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 99) < 70);
      b = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 99) < 3);
      if (v && m_fill == 0 && !m_wait) f = 0;
      step(v, 2'($urandom), f, b);
    end
    check("sym_total", bus.sym_cnt, n_acc);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_sched.md
VITERBI_SCHED -- requirements
Module: viterbi_sched

Interface
REQ-001 Parameter BLK_LEN, default 256, symbols per survivor-memory block; power of two, at least 4.
REQ-002 Parameter AW, default $clog2(BLK_LEN), survivor-memory address width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  a received symbol pair is offered.
REQ-006 rx_pair_in  input  2  received symbol pair.
REQ-007 in_ready  output  1  the controller accepts the pair this cycle.
REQ-008 flush  input  1  single-cycle request to close a partial block.
REQ-009 rx_pair  output  2  registered pair driven to the branch-metric unit.
REQ-010 acs_en  output  1  add-compare-select stage updates this cycle.
REQ-011 wr_addr  output  AW  survivor-memory write address for the current acs_en cycle.
REQ-012 wr_bank  output  1  survivor-memory bank being written.
REQ-013 tb_req  output  1  single-cycle traceback start pulse.
REQ-014 tb_bank  output  1  bank to trace back; valid while tb_req=1.
REQ-015 tb_len  output  AW+1  symbols in that bank; valid while tb_req=1.
REQ-016 tb_busy  input  1  the traceback engine is active.
REQ-017 sym_cnt  output  32  total symbols accepted since reset; wraps modulo 2^32.

Function
REQ-018 The controller has states RUN and WAIT_TB.
REQ-019 in_ready is 1 exactly when the state is RUN.
REQ-020 An accept is in_valid=1 and in_ready=1 in the same cycle.
REQ-021 On an accept, the next cycle has rx_pair=rx_pair_in, acs_en=1 and wr_addr equal to the fill count, so latency is exactly 1 cycle; otherwise acs_en=0 and rx_pair holds its value.
REQ-022 The fill count, 0..BLK_LEN-1, increments on each accept and returns to 0 when a block closes.
REQ-023 busy_eff = tb_busy OR (tb_req was 1 in the previous cycle), which covers the engine's one-cycle tb_busy latency.
REQ-024 A block closes on an accept at fill count BLK_LEN-1, or on flush with a nonzero fill count.
REQ-025 On close with busy_eff=0, the next cycle has tb_req=1, tb_bank=old wr_bank, tb_len=symbols in the block; wr_bank toggles and the state stays RUN.
REQ-026 On close with busy_eff=1, the state moves to WAIT_TB and wr_bank holds.
REQ-027 In WAIT_TB, on the first cycle with busy_eff=0, the next cycle issues tb_req with the stored bank and length, toggles wr_bank and returns to RUN.
REQ-028 flush with an accept in the same cycle counts that symbol in the block being closed; if this makes BLK_LEN symbols, exactly one tb_req is issued.
REQ-029 flush with a zero fill count, or while in WAIT_TB, is ignored.
REQ-030 tb_req is never 1 on two consecutive cycles.
REQ-031 No acs_en=1 cycle writes the bank named by a pending or active traceback.

Reset
REQ-032 rst asynchronously forces state=RUN, fill count=0, rx_pair=0, acs_en=0, wr_addr=0, wr_bank=0, tb_req=0, tb_bank=0, tb_len=0 and sym_cnt=0.
REQ-033 Reset mid-block discards the partial block and issues no tb_req.
REQ-034 After reset deasserts, in_ready=1 from the first clock edge.

Structure
REQ-035 A shared package viterbi_pkg holds the state enum, the default BLK_LEN and the symbol-pair typedef (logic [1:0]).
REQ-036 The block is a single module with no sub-modules; the traceback-length capture and bank toggle share one always_ff block.

Verification
REQ-037 Scenario: reset, then 256 consecutive accepts with tb_busy=0 -> acs_en high for 256 cycles, wr_addr 0..255, tb_req one cycle after the last accept with tb_bank=0 and tb_len=256, then wr_bank=1.
REQ-038 Scenario: 100 accepts then flush -> tb_req with tb_len=100 and tb_bank=0; the next accept writes wr_addr=0 in bank 1.
REQ-039 Scenario: tb_busy held 1 across the second block close -> in_ready=0 (WAIT_TB) until tb_busy falls, then tb_req with tb_bank=1 one cycle later, then in_ready=1.
REQ-040 Scenario: flush coinciding with the 256th accept -> exactly one tb_req with tb_len=256.
REQ-041 Scenario: rst asserted asynchronously mid-block at fill count 50 -> all outputs immediately at reset values, no tb_req, sym_cnt=0.
REQ-042 Scenario: random in_valid at 70% with random tb_busy for 10k cycles -> checker confirms REQ-030 and REQ-031, and sym_cnt equals the number of accepts.
